// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; 2-flop synchroniser, oversampled by CLKS_PER_BIT clocks per bit.
// Latency: falling start edge to received strobe = 3 + (HALF+1) + 9*CLKS_PER_BIT clocks.
// Backpressure: none; a good byte strobes received for one cycle and is held on rx_byte.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   received   one-cycle strobe, rx_byte holds a new good byte
//   rx_byte    last good byte, held until the next good byte
//   frame_err  one-cycle strobe, stop bit sampled low (no byte delivered)
module uart_rx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Start bit is checked at its centre; from there each data/stop sample is one full bit later.
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic          rx_meta;
    logic          rx_s;

    // Synchroniser resets to the idle-line level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= '0;
            sh        <= '0;
            rx_byte   <= '0;
            received  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            received  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        if (!rx_s) begin
                            cnt   <= '0;
                            bitn  <= '0;
                            state <= DATA;
                        end else begin
                            // Line went high again before mid start bit: a glitch, not a frame.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        sh  <= {rx_s, sh[7:1]};
                        cnt <= '0;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        // Leaving at mid stop bit gives half a bit of slack for a back-to-back start.
                        cnt <= '0;
                        if (rx_s) begin
                            rx_byte  <= sh;
                            received <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must return high before a new start can be recognised.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       received;
    logic       frame_err;
    logic [7:0] rx_byte;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .received  (received),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts strobe cycles (a stretched strobe counts more than once).
    int         rcv_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         last_rcv_cyc = 0;
    logic [7:0] rcv_q[$];
    always @(negedge clk) begin
        if (received) begin
            rcv_cnt++;
            rcv_q.push_back(rx_byte);
            last_rcv_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (received && frame_err) both_cnt++;
    end

    int checks = 0;
    int passed = 0;
    int start_cyc = 0;
    int r0, f0, qs;

    localparam int BCLK = 104;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a negedge; drives one full frame, stop bit for a full period.
    task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bclk) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        checks++; if (received !== 1'b0) $display("FAIL reset_received: got %b want 0", received); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        checks++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", rx_byte); else passed++;
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_single();
        r0 = rcv_cnt; f0 = ferr_cnt;
        send_frame(8'h55, BCLK, 1'b1);
        idle(200);
        checks++; if (rcv_cnt - r0 !== 1) $display("FAIL single_count: got %0d want 1", rcv_cnt - r0); else passed++;
        checks++; if (rx_byte !== 8'h55) $display("FAIL single_byte: got %h want 55", rx_byte); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); else passed++;
        // 2 sync + 1 + (51+1) + 9*104 = 991
        checks++; if (last_rcv_cyc - start_cyc !== 991) $display("FAIL single_latency: got %0d want 991", last_rcv_cyc - start_cyc); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA5;
        r0 = rcv_cnt; qs = rcv_q.size();
        for (int i = 0; i < 3; i++) send_frame(exp[i], BCLK, 1'b1);
        idle(200);
        checks++; if (rcv_cnt - r0 !== 3) $display("FAIL b2b_count: got %0d want 3", rcv_cnt - r0); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rcv_q.size() <= qs + i) $display("FAIL b2b_byte%0d: got none want %h", i, exp[i]);
            else if (rcv_q[qs + i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, rcv_q[qs + i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        r0 = rcv_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(300);
        checks++; if (rcv_cnt - r0 !== 0) $display("FAIL glitch_received: got %0d want 0", rcv_cnt - r0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); else passed++;
        send_frame(8'h3C, BCLK, 1'b1);
        idle(200);
        checks++; if (rcv_cnt - r0 !== 1) $display("FAIL glitch_after_count: got %0d want 1", rcv_cnt - r0); else passed++;
        checks++; if (rx_byte !== 8'h3C) $display("FAIL glitch_after_byte: got %h want 3c", rx_byte); else passed++;
    endtask

    task automatic test_frame_err();
        r0 = rcv_cnt; f0 = ferr_cnt;
        send_frame(8'h12, BCLK, 1'b1);
        send_frame(8'h34, BCLK, 1'b0);
        rx = 1'b1;
        idle(300);
        checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); else passed++;
        checks++; if (rcv_cnt - r0 !== 1) $display("FAIL ferr_rcv_count: got %0d want 1", rcv_cnt - r0); else passed++;
        checks++; if (rx_byte !== 8'h12) $display("FAIL ferr_byte_held: got %h want 12", rx_byte); else passed++;
        send_frame(8'h56, BCLK, 1'b1);
        idle(200);
        checks++; if (rx_byte !== 8'h56) $display("FAIL ferr_next_byte: got %h want 56", rx_byte); else passed++;
        checks++; if (rcv_cnt - r0 !== 2) $display("FAIL ferr_next_count: got %0d want 2", rcv_cnt - r0); else passed++;
        checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_total: got %0d want 1", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_break();
        r0 = rcv_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        idle(3 * 10 * BCLK);
        checks++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr: got %0d want 1", ferr_cnt - f0); else passed++;
        checks++; if (rcv_cnt - r0 !== 0) $display("FAIL break_received: got %0d want 0", rcv_cnt - r0); else passed++;
        rx = 1'b1;
        idle(300);
        checks++; if (rcv_cnt - r0 !== 0) $display("FAIL break_release: got %0d want 0", rcv_cnt - r0); else passed++;
        send_frame(8'hE7, BCLK, 1'b1);
        idle(200);
        checks++; if (rx_byte !== 8'hE7) $display("FAIL break_next_byte: got %h want e7", rx_byte); else passed++;
        checks++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr_total: got %0d want 1", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h81;
        r0 = rcv_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (BCLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BCLK) @(negedge clk);
        end
        rx = d[4];
        idle(50);
        rst = 1'b1;
        #1;
        checks++; if (rx_byte !== 8'h00) $display("FAIL midrst_rx_byte: got %h want 00", rx_byte); else passed++;
        checks++; if (received !== 1'b0) $display("FAIL midrst_received: got %b want 0", received); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL midrst_frame_err: got %b want 0", frame_err); else passed++;
        @(negedge clk);
        rx = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(2000);
        checks++; if (rcv_cnt - r0 !== 0) $display("FAIL midrst_no_rcv: got %0d want 0", rcv_cnt - r0); else passed++;
        checks++; if (ferr_cnt - f0 !== 0) $display("FAIL midrst_no_ferr: got %0d want 0", ferr_cnt - f0); else passed++;
        send_frame(8'h7E, BCLK, 1'b1);
        idle(200);
        checks++; if (rx_byte !== 8'h7E) $display("FAIL midrst_next_byte: got %h want 7e", rx_byte); else passed++;
        checks++; if (rcv_cnt - r0 !== 1) $display("FAIL midrst_next_count: got %0d want 1", rcv_cnt - r0); else passed++;
    endtask

    task automatic test_tolerance();
        // 97% baud -> 107 clocks/bit, 103% baud -> 101 clocks/bit
        int rates [2];
        rates[0] = 107; rates[1] = 101;
        for (int k = 0; k < 2; k++) begin
            r0 = rcv_cnt; f0 = ferr_cnt;
            send_frame(8'hC3, rates[k], 1'b1);
            idle(300);
            checks++; if (rx_byte !== 8'hC3) $display("FAIL tol_byte_%0d: got %h want c3", rates[k], rx_byte); else passed++;
            checks++; if (rcv_cnt - r0 !== 1 || ferr_cnt - f0 !== 0)
                $display("FAIL tol_strobes_%0d: got rcv %0d ferr %0d want 1 0", rates[k], rcv_cnt - r0, ferr_cnt - f0);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
        test_tolerance();
        checks++; if (both_cnt !== 0) $display("FAIL strobes_together: got %0d want 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
